// File: rtl/uncomplement_norm_pkg.sv
// Shared widths for the uncomplement/normalize stage and the forward complement stage.
// The lane width is built from the significand width and the low-side expansion.
package uncomplement_norm_pkg;

    localparam int unsigned SIGWIDTH       = 11;
    localparam int unsigned LOW_EXPAND     = 1;
    localparam int unsigned UNSIGNED_WIDTH = SIGWIDTH + LOW_EXPAND;
    localparam int unsigned LANES          = 4;
    localparam int unsigned LANE_W         = SIGWIDTH + 4 + LOW_EXPAND;
    localparam int unsigned LANE_LZW       = $clog2(LANE_W + 1);

endpackage

// File: rtl/uncomplement_norm_lane_lzc.sv
// lane_lzc: leading-zero count and left-normalize of one unsigned lane magnitude.
// Compiled only when UNCOMP_LZC_EN is defined.
`ifdef UNCOMP_LZC_EN
module lane_lzc
    import uncomplement_norm_pkg::*;
#(
    parameter int unsigned W   = LANE_W,
    parameter int unsigned LZW = $clog2(W + 1)
) (
    input  logic [W-1:0]   mag,
    output logic [LZW-1:0] lzc,
    output logic [W-1:0]   norm
);

    logic found;

    // A zero magnitude keeps the default count of W, and the shift then yields 0.
    always_comb begin
        found = 1'b0;
        lzc   = LZW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (!found && mag[W-1-i]) begin
                found = 1'b1;
                lzc   = LZW'(i);
            end
        end
        norm = mag << lzc;
    end

endmodule
`endif

// File: rtl/uncomplement_norm.sv
// 4-lane two's-complement to sign/magnitude/zero converter, 2-stage valid/ready pipeline.
// Define UNCOMP_LZC_EN to add per-lane leading-zero count and left-normalization.
module uncomplement_norm
    import uncomplement_norm_pkg::*;
#(
    parameter int unsigned W   = LANE_W,
    parameter int unsigned LZW = $clog2(W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_num,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out_sign,
    output logic [LANES*W-1:0]   out_mag,
    output logic [LANES-1:0]     out_zero,
    output logic [LANES*LZW-1:0] out_lzc
);

    logic                 s1_valid;
    logic                 s2_ready;
    logic [LANES-1:0]     s1_sign;
    logic [LANES-1:0]     s1_zero;
    logic [LANES*W-1:0]   s1_mag;

    logic [LANES-1:0]     s1_sign_d;
    logic [LANES-1:0]     s1_zero_d;
    logic [LANES*W-1:0]   s1_mag_d;
    logic [LANES*W-1:0]   s2_mag_d;

    assign s2_ready = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_ready;

    // Magnitude is W-bit unsigned, so the most-negative input maps to 1<<(W-1) exactly.
    always_comb begin
        logic [W-1:0] lane;
        lane      = '0;
        s1_sign_d = '0;
        s1_zero_d = '0;
        s1_mag_d  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane                 = in_num[i*W +: W];
            s1_sign_d[i]         = lane[W-1];
            s1_zero_d[i]         = (lane == '0);
            s1_mag_d[i*W +: W]   = lane[W-1] ? (~lane + W'(1)) : lane;
        end
    end

`ifdef UNCOMP_LZC_EN
    logic [LANES*LZW-1:0] s2_lzc_d;

    for (genvar g = 0; g < LANES; g++) begin : g_lzc
        lane_lzc #(
            .W   (W),
            .LZW (LZW)
        ) u_lane_lzc (
            .mag  (s1_mag[g*W +: W]),
            .lzc  (s2_lzc_d[g*LZW +: LZW]),
            .norm (s2_mag_d[g*W +: W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_lzc <= '0;
        end else if (s2_ready && s1_valid) begin
            out_lzc <= s2_lzc_d;
        end
    end
`else
    assign s2_mag_d = s1_mag;
    assign out_lzc  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= '0;
            s1_zero  <= '0;
            s1_mag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= s1_sign_d;
                s1_zero <= s1_zero_d;
                s1_mag  <= s1_mag_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sign  <= '0;
            out_zero  <= '0;
            out_mag   <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign <= s1_sign;
                out_zero <= s1_zero;
                out_mag  <= s2_mag_d;
            end
        end
    end

endmodule

// File: tb/tb_uncomplement_norm.sv
// Scoreboard bench for uncomplement_norm; expectations follow UNCOMP_LZC_EN when defined.
module tb_uncomplement_norm;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_num;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_sign;
    logic [63:0] out_mag;
    logic [3:0]  out_zero;
    logic [19:0] out_lzc;

    always #5 clk = ~clk;

    uncomplement_norm dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_zero  (out_zero),
        .out_lzc   (out_lzc)
    );

    typedef struct {
        logic [3:0]  sign;
        logic [3:0]  zero;
        logic [63:0] mag;
        logic [19:0] lzc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   accepted = 0;
    int   n_out = 0;

    // Hand-computed vectors; lane 3 is the leftmost hex group.
    logic [63:0] tv_in   [5] = '{64'hFFFF_0003_8000_0000, 64'h0001_7FFF_FFFE_0100,
                                 64'h8001_0000_00FF_F000, 64'h0000_0000_0000_0000,
                                 64'h1234_FF00_4000_FFF5};
    logic [3:0]  tv_sign [5] = '{4'b1010, 4'b0010, 4'b1001, 4'b0000, 4'b0101};
    logic [3:0]  tv_zero [5] = '{4'b0001, 4'b0000, 4'b0100, 4'b1111, 4'b0000};
    logic [63:0] tv_raw  [5] = '{64'h0001_0003_8000_0000, 64'h0001_7FFF_0002_0100,
                                 64'h7FFF_0000_00FF_1000, 64'h0000_0000_0000_0000,
                                 64'h1234_0100_4000_000B};
    logic [63:0] tv_norm [5] = '{64'h8000_C000_8000_0000, 64'h8000_FFFE_8000_8000,
                                 64'hFFFE_0000_FF00_8000, 64'h0000_0000_0000_0000,
                                 64'h91A0_8000_8000_B000};
    logic [19:0] tv_lzc  [5] = '{{5'd15, 5'd14, 5'd0,  5'd16}, {5'd15, 5'd1,  5'd14, 5'd7},
                                 {5'd1,  5'd16, 5'd8,  5'd3},  {5'd16, 5'd16, 5'd16, 5'd16},
                                 {5'd3,  5'd7,  5'd1,  5'd12}};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    function automatic exp_t from_table(input int k);
        exp_t e;
        e.sign = tv_sign[k];
        e.zero = tv_zero[k];
`ifdef UNCOMP_LZC_EN
        e.mag  = tv_norm[k];
        e.lzc  = tv_lzc[k];
`else
        e.mag  = tv_raw[k];
        e.lzc  = '0;
`endif
        return e;
    endfunction

    function automatic exp_t model(input logic [63:0] v);
        exp_t        e;
        logic [15:0] x;
        logic [15:0] m;
        int          sv;
        int          cnt;
        e.sign = '0; e.zero = '0; e.mag = '0; e.lzc = '0;
        for (int l = 0; l < 4; l++) begin
            x   = v[16*l +: 16];
            sv  = int'($signed(x));
            m   = (sv < 0) ? 16'(-sv) : 16'(sv);
            cnt = 16;
            for (int b = 0; b < 16; b++) begin
                if (cnt == 16 && m[15-b]) cnt = b;
            end
            e.sign[l] = (sv < 0);
            e.zero[l] = (sv == 0);
`ifdef UNCOMP_LZC_EN
            e.mag[16*l +: 16] = (cnt == 16) ? 16'h0 : (m << cnt);
            e.lzc[5*l +: 5]   = 5'(cnt);
`else
            e.mag[16*l +: 16] = m;
`endif
        end
        return e;
    endfunction

    task automatic send(input logic [63:0] v, input exp_t e, output int waits);
        logic ok;
        int   n;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_num   = v;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            n++;
        end
        waits = n - 1;
        if (ok) begin
            q.push_back(e);
            accepted++;
        end else begin
            checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 64'(q.size()), 64'd0);
    endtask

    // Monitor: pops on each output transfer and checks outputs hold while stalled.
    logic        hold_act = 1'b0;
    logic [3:0]  h_sign, h_zero;
    logic [63:0] h_mag;
    logic [19:0] h_lzc;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_act = 1'b0;
        end else begin
            if (hold_act) begin
                chk("hold_sign", 64'(out_sign), 64'(h_sign));
                chk("hold_mag",  out_mag,       h_mag);
                chk("hold_zero", 64'(out_zero), 64'(h_zero));
                chk("hold_lzc",  64'(out_lzc),  64'(h_lzc));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_out: got output mag %h, required no output", out_mag);
                end else begin
                    e = q.pop_front();
                    chk("out_sign", 64'(out_sign), 64'(e.sign));
                    chk("out_mag",  out_mag,       e.mag);
                    chk("out_zero", 64'(out_zero), 64'(e.zero));
                    chk("out_lzc",  64'(out_lzc),  64'(e.lzc));
                    n_out++;
                end
            end
            hold_act = out_valid && !out_ready;
            h_sign = out_sign; h_mag = out_mag; h_zero = out_zero; h_lzc = out_lzc;
        end
    end

    logic rnd_on = 1'b0;

    initial begin
        int w;
        int stalls;
        int base;
        logic [63:0] v;

        rst = 1'b1; in_valid = 1'b0; in_num = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_mag",   out_mag,        64'd0);
        chk("rst_out_sign",  64'(out_sign),  64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single vector into an empty pipe: out_valid appears on the second cycle.
        send(tv_in[0], from_table(0), w);
        @(negedge clk);
        chk("lat_cycle1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_out_valid", 64'(out_valid), 64'd1);
        drain();

        // Back-to-back stream at full rate.
        stalls = 0;
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            send(tv_in[(i + 1) % 5], from_table((i + 1) % 5), w);
            stalls += w;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("stream_in_ready_stalls", 64'(stalls), 64'd0);
        chk("stream_outputs", 64'(n_out - base), 64'd8);
        drain();

        // Backpressure: only two vectors fit while out_ready is low.
        out_ready = 1'b0;
        base = accepted;
        fork
            begin
                send(tv_in[2], from_table(2), w);
                send(tv_in[4], from_table(4), w);
                send(tv_in[1], from_table(1), w);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("stall_accepted", 64'(accepted - base), 64'd2);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        send(tv_in[2], from_table(2), w);
        send(tv_in[3], from_table(3), w);
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_out_mag",   out_mag,        64'd0);
        chk("midrst_out_zero",  64'(out_zero),  64'd0);
        chk("midrst_out_lzc",   64'(out_lzc),   64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(tv_in[1], from_table(1), w);
        @(negedge clk);
        chk("postrst_cycle1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("postrst_cycle2_out_valid", 64'(out_valid), 64'd1);
        drain();

        // Random lanes with random gaps and random backpressure.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    for (int l = 0; l < 4; l++) begin
                        case ($urandom % 6)
                            0:       v[16*l +: 16] = 16'h0000;
                            1:       v[16*l +: 16] = 16'h8000;
                            2:       v[16*l +: 16] = 16'hFFFF;
                            default: v[16*l +: 16] = 16'($urandom);
                        endcase
                    end
                    send(v, model(v), w);
                    if ($urandom % 4 == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom % 3 != 0);
                end
            end
        join
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
